ahb_master_if: RTL and testbench

AHB_MASTER_IF -- requirements
Module: ahb_master_if

---
 rtl/ahb_master_if_if.sv | 38 +++
 rtl/ahb_master_if.sv | 163 ++++++++++++++++
 tb/tb_ahb_master_if.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_if_if.sv
// Signal bundle between the user command/response side, the AHB bus and ahb_master_if.
// The master modport is the bridge's view; slave is the view of whatever drives commands and models the bus.
interface ahb_master_if_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_lock;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        hbusreq;
    logic        hlock;
    logic        hgrant;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        input  cmd_valid, cmd_write, cmd_lock, cmd_addr, cmd_wdata,
        input  hgrant, hrdata, hready, hresp,
        output cmd_ready, hbusreq, hlock, haddr, htrans, hwrite, hsize, hwdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_lock, cmd_addr, cmd_wdata,
        output hgrant, hrdata, hready, hresp,
        input  cmd_ready, hbusreq, hlock, haddr, htrans, hwrite, hsize, hwdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ahb_master_if.sv
// Single-word AHB master: takes one user command, arbitrates for the bus and runs one NONSEQ transfer.
// Optional AHB_MASTER_RETRY_EN: an ERROR response reissues the transfer, up to two retries.
module ahb_master_if (
    input  logic hclk,
    input  logic hreset,
    ahb_master_if_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, ADDR, DATA} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] cap_addr_q, cap_addr_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;
    logic        cap_write_q, cap_write_d;
    logic        cap_lock_q, cap_lock_d;
    logic        hbusreq_q, hbusreq_d;
    logic        hlock_q, hlock_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        retry_now;
`ifdef AHB_MASTER_RETRY_EN
    logic [1:0]  retry_q, retry_d;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= IDLE;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_write_q <= 1'b0;
            cap_lock_q  <= 1'b0;
            hbusreq_q   <= 1'b0;
            hlock_q     <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef AHB_MASTER_RETRY_EN
            retry_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_write_q <= cap_write_d;
            cap_lock_q  <= cap_lock_d;
            hbusreq_q   <= hbusreq_d;
            hlock_q     <= hlock_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef AHB_MASTER_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_write_d = cap_write_q;
        cap_lock_d  = cap_lock_q;
        hbusreq_d   = hbusreq_q;
        hlock_d     = hlock_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        retry_now   = 1'b0;
`ifdef AHB_MASTER_RETRY_EN
        retry_d     = retry_q;
        retry_now   = bus.hresp && (retry_q != 2'd2);
`endif

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cap_addr_d  = {bus.cmd_addr[31:2], 2'b00};
                    cap_wdata_d = bus.cmd_wdata;
                    cap_write_d = bus.cmd_write;
                    cap_lock_d  = bus.cmd_lock;
                    hbusreq_d   = 1'b1;
                    hlock_d     = bus.cmd_lock;
                    state_d     = REQ;
`ifdef AHB_MASTER_RETRY_EN
                    retry_d     = 2'd0;
`endif
                end
            end
            REQ: begin
                if (bus.hgrant && bus.hready) begin
                    state_d  = ADDR;
                    htrans_d = HTRANS_NONSEQ;
                    haddr_d  = cap_addr_q;
                    hwrite_d = cap_write_q;
                    // A locked transfer keeps requesting so the arbiter cannot move away mid-transfer.
                    if (!cap_lock_q) begin
                        hbusreq_d = 1'b0;
                    end
                end
            end
            ADDR: begin
                if (bus.hready) begin
                    state_d  = DATA;
                    htrans_d = HTRANS_IDLE;
                    if (cap_write_q) begin
                        hwdata_d = cap_wdata_q;
                    end
                end
            end
            DATA: begin
                if (bus.hready) begin
                    if (retry_now) begin
                        state_d   = REQ;
                        hbusreq_d = 1'b1;
                        hlock_d   = cap_lock_q;
`ifdef AHB_MASTER_RETRY_EN
                        retry_d   = retry_q + 2'd1;
`endif
                    end else begin
                        state_d     = IDLE;
                        hbusreq_d   = 1'b0;
                        hlock_d     = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = cap_write_q ? 32'h0 : bus.hrdata;
                        rsp_err_d   = bus.hresp;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.hbusreq   = hbusreq_q;
    assign bus.hlock     = hlock_q;
    assign bus.htrans    = htrans_q;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hsize     = 3'b010;
    assign bus.hwdata    = hwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: each task runs one scenario and checks hand-computed cycle timing.
module tb_ahb_master_if;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ahb_master_if_if bus ();

    ahb_master_if dut (
        .hclk   (clk),
        .hreset (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic lk, input logic [31:0] a, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_lock  = lk;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready act=%b exp=1", bus.cmd_ready); end
        checks++; if ({bus.hbusreq, bus.hlock, bus.hwrite, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin failures++; $display("FAIL rst_flags act=%b exp=00000", {bus.hbusreq, bus.hlock, bus.hwrite, bus.rsp_valid, bus.rsp_err}); end
        checks++; if ({bus.htrans, bus.haddr, bus.hwdata, bus.rsp_rdata} !== 98'h0) begin failures++; $display("FAIL rst_buses htrans=%h haddr=%h hwdata=%h rdata=%h exp=0", bus.htrans, bus.haddr, bus.hwdata, bus.rsp_rdata); end
        checks++; if (bus.hsize !== 3'b010) begin failures++; $display("FAIL rst_hsize act=%b exp=010", bus.hsize); end
        tick();
        rst = 1'b0;
        tick();
        $display("TXN reset done");
    endtask

    task automatic test_write();
        bus.hgrant = 1'b1; bus.hready = 1'b1; bus.hresp = 1'b0;
        issue(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_ready act=%b exp=1", bus.cmd_ready); end
        tick(); // E0
        bus.cmd_valid = 1'b0;
        checks++; if ({bus.hbusreq, bus.htrans, bus.cmd_ready} !== 4'b1000) begin failures++; $display("FAIL wr_req hbusreq/htrans/ready act=%b exp=1000", {bus.hbusreq, bus.htrans, bus.cmd_ready}); end
        tick(); // E1
        checks++; if (bus.htrans !== 2'b10 || bus.haddr !== 32'h10 || bus.hwrite !== 1'b1) begin failures++; $display("FAIL wr_addr htrans=%b haddr=%h hwrite=%b exp=10/00000010/1", bus.htrans, bus.haddr, bus.hwrite); end
        checks++; if (bus.hbusreq !== 1'b0) begin failures++; $display("FAIL wr_busreq_drop act=%b exp=0", bus.hbusreq); end
        tick(); // E2
        checks++; if (bus.htrans !== 2'b00 || bus.hwdata !== 32'hDEAD_BEEF || bus.haddr !== 32'h10) begin failures++; $display("FAIL wr_data htrans=%b hwdata=%h haddr=%h exp=00/deadbeef/00000010", bus.htrans, bus.hwdata, bus.haddr); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_early_rsp act=%b exp=0", bus.rsp_valid); end
        tick(); // E3
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_rsp valid=%b err=%b rdata=%h ready=%b exp=1/0/0/1", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.cmd_ready); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_pulse act=%b exp=0", bus.rsp_valid); end
        $display("TXN write addr=00000010 data=deadbeef");
    endtask

    task automatic test_read_wait();
        bus.hgrant = 1'b0; bus.hready = 1'b1; bus.hresp = 1'b0;
        issue(1'b0, 1'b0, 32'h0000_0023, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.hbusreq !== 1'b1 || bus.htrans !== 2'b00) begin failures++; $display("FAIL rd_wait%0d hbusreq=%b htrans=%b exp=1/00", i, bus.hbusreq, bus.htrans); end
            tick();
        end
        bus.hgrant = 1'b1;
        tick();
        checks++; if (bus.htrans !== 2'b10 || bus.haddr !== 32'h20 || bus.hwrite !== 1'b0) begin failures++; $display("FAIL rd_addr htrans=%b haddr=%h hwrite=%b exp=10/00000020/0", bus.htrans, bus.haddr, bus.hwrite); end
        tick();
        bus.hready = 1'b0;
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL rd_waitstate valid=%b ready=%b exp=0/0", bus.rsp_valid, bus.cmd_ready); end
        bus.hready = 1'b1; bus.hrdata = 32'h1234_5678;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp valid=%b rdata=%h err=%b exp=1/12345678/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
        bus.hrdata = 32'h0;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rd_rsp_pulse valid=%b rdata=%h exp=0/12345678", bus.rsp_valid, bus.rsp_rdata); end
        $display("TXN read addr=00000020 data=12345678 grant_wait=3 wait_states=2");
    endtask

    task automatic test_lock();
        bus.hgrant = 1'b1; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'hCAFE_F00D;
        issue(1'b0, 1'b1, 32'h0000_0040, 32'h0);
        tick();
        bus.cmd_valid = 1'b0; bus.cmd_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.hlock !== 1'b1 || bus.hbusreq !== 1'b1) begin failures++; $display("FAIL lk_held%0d hlock=%b hbusreq=%b exp=1/1", i, bus.hlock, bus.hbusreq); end
            tick();
        end
        checks++; if (bus.hlock !== 1'b0 || bus.hbusreq !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL lk_done hlock=%b hbusreq=%b valid=%b rdata=%h exp=0/0/1/cafef00d", bus.hlock, bus.hbusreq, bus.rsp_valid, bus.rsp_rdata); end
        bus.hrdata = 32'h0;
        tick();
        $display("TXN locked read addr=00000040 data=cafef00d");
    endtask

    task automatic test_error();
        int nonseq;
        int pulses;
        logic err;
        bit done;
        int exp_nonseq;
`ifdef AHB_MASTER_RETRY_EN
        exp_nonseq = 3;
`else
        exp_nonseq = 1;
`endif
        nonseq = 0; pulses = 0; err = 1'b0; done = 1'b0;
        bus.hgrant = 1'b1; bus.hready = 1'b1; bus.hresp = 1'b1;
        issue(1'b0, 1'b0, 32'h0000_0200, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (bus.rsp_valid === 1'b1) pulses++;
            if (bus.htrans === 2'b10) begin
                nonseq++;
                tick();
                bus.hready = 1'b0;
                tick();
                checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL err_hold attempt=%0d valid=%b exp=0", nonseq, bus.rsp_valid); end
                bus.hready = 1'b1;
                tick();
                if (bus.rsp_valid === 1'b1) begin
                    pulses++; err = bus.rsp_err; done = 1'b1;
                end
            end else begin
                tick();
            end
        end
        checks++; if (!done) begin failures++; $display("FAIL err_timeout act=no_rsp exp=rsp within 40 cycles"); end
        checks++; if (nonseq !== exp_nonseq || pulses !== 1 || err !== 1'b1) begin failures++; $display("FAIL err_result nonseq=%0d pulses=%0d err=%b exp=%0d/1/1", nonseq, pulses, err, exp_nonseq); end
        bus.hresp = 1'b0;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL err_after valid=%b ready=%b exp=0/1", bus.rsp_valid, bus.cmd_ready); end
        $display("TXN error read addr=00000200 attempts=%0d rsp_err=%b", nonseq, err);
    endtask

    task automatic test_reset_mid();
        bus.hgrant = 1'b1; bus.hready = 1'b1; bus.hresp = 1'b0;
        issue(1'b1, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5);
        tick();
        bus.cmd_valid = 1'b0; bus.cmd_lock = 1'b0;
        tick();
        tick();
        checks++; if (bus.hwdata !== 32'hA5A5_A5A5 || bus.hlock !== 1'b1) begin failures++; $display("FAIL rm_data hwdata=%h hlock=%b exp=a5a5a5a5/1", bus.hwdata, bus.hlock); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({bus.hbusreq, bus.hlock, bus.hwrite, bus.rsp_valid, bus.htrans} !== 6'b0 || bus.haddr !== 32'h0 || bus.hwdata !== 32'h0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rm_async flags=%b haddr=%h hwdata=%h ready=%b exp=0/0/0/1", {bus.hbusreq, bus.hlock, bus.hwrite, bus.rsp_valid, bus.htrans}, bus.haddr, bus.hwdata, bus.cmd_ready); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.hbusreq !== 1'b0) begin failures++; $display("FAIL rm_release valid=%b ready=%b hbusreq=%b exp=0/1/0", bus.rsp_valid, bus.cmd_ready, bus.hbusreq); end
        $display("TXN write aborted by reset addr=00000080");
    endtask

    task automatic test_back_to_back();
        bus.hgrant = 1'b1; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'h8765_4321;
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111);
        tick();
        issue(1'b0, 1'b0, 32'h0000_0104, 32'h2222_2222);
        tick();
        checks++; if (bus.haddr !== 32'h100 || bus.hwrite !== 1'b1) begin failures++; $display("FAIL bb_addr1 haddr=%h hwrite=%b exp=00000100/1", bus.haddr, bus.hwrite); end
        tick();
        checks++; if (bus.hwdata !== 32'h1111_1111) begin failures++; $display("FAIL bb_data1 hwdata=%h exp=11111111", bus.hwdata); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL bb_rsp1 valid=%b rdata=%h ready=%b exp=1/0/1", bus.rsp_valid, bus.rsp_rdata, bus.cmd_ready); end
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.hbusreq !== 1'b1 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bb_accept2 valid=%b hbusreq=%b ready=%b exp=0/1/0", bus.rsp_valid, bus.hbusreq, bus.cmd_ready); end
        tick();
        checks++; if (bus.htrans !== 2'b10 || bus.haddr !== 32'h104 || bus.hwrite !== 1'b0) begin failures++; $display("FAIL bb_addr2 htrans=%b haddr=%h hwrite=%b exp=10/00000104/0", bus.htrans, bus.haddr, bus.hwrite); end
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h8765_4321 || bus.hwdata !== 32'h1111_1111) begin failures++; $display("FAIL bb_rsp2 valid=%b rdata=%h hwdata=%h exp=1/87654321/11111111", bus.rsp_valid, bus.rsp_rdata, bus.hwdata); end
        tick();
        $display("TXN back-to-back write 00000100 then read 00000104");
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_lock = 1'b0;
        bus.cmd_addr = 32'h0; bus.cmd_wdata = 32'h0;
        bus.hgrant = 1'b0; bus.hrdata = 32'h0; bus.hready = 1'b1; bus.hresp = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_lock();
        test_error();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL tb_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
